motor_step_drv_if: RTL and testbench

//  Output stage between the step-pulse generator and the external stepper driver.
//  - Takes single-cycle step requests plus dir/enable/hold-off from the AXI-configured motor core.
//  - Enforces driver timing on the pins: enable settle, dir setup and hold, minimum step high/low width.
//  - Buffers one step request, counts dropped requests, tracks signed absolute position.

---
 rtl/motor_step_drv_if.sv | 172 +++++++++++++++++
 tb/tb_motor_step_drv_if.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/motor_step_drv_if.sv
// Stepper driver pin stage: enable settle, dir setup/hold, step pulse widths, one-deep request buffer, position and drop counters.
// Optional soft position window: define MOTOR_SOFT_LIMIT_EN.
module motor_step_drv_if #(
  parameter int unsigned PULSE_HI_CYC  = 100,
  parameter int unsigned PULSE_LO_CYC  = 100,
  parameter int unsigned DIR_SETUP_CYC = 500,
  parameter int unsigned EN_SETTLE_CYC = 5000,
  parameter int unsigned POS_W         = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_step,
  input  logic                    i_dir,
  input  logic                    i_en,
  input  logic                    i_hold_off,
  input  logic                    i_pos_clr,
`ifdef MOTOR_SOFT_LIMIT_EN
  input  logic signed [POS_W-1:0] i_pos_min,
  input  logic signed [POS_W-1:0] i_pos_max,
  output logic                    o_limit,
`endif
  output logic                    o_motor_step,
  output logic                    o_motor_dir,
  output logic                    o_motor_en,
  output logic                    o_motor_hold_off,
  output logic                    o_busy,
  output logic signed [POS_W-1:0] o_pos,
  output logic [15:0]             o_drop_cnt
);

  // Counters load N-1 and leave the state on reaching zero, so a zero parameter behaves as 1.
  localparam logic [15:0] HI_LD    = 16'((PULSE_HI_CYC  == 0) ? 0 : PULSE_HI_CYC  - 1);
  localparam logic [15:0] LO_LD    = 16'((PULSE_LO_CYC  == 0) ? 0 : PULSE_LO_CYC  - 1);
  localparam logic [15:0] SETUP_LD = 16'((DIR_SETUP_CYC == 0) ? 0 : DIR_SETUP_CYC - 1);
  localparam logic [15:0] EN_LD    = 16'((EN_SETTLE_CYC == 0) ? 0 : EN_SETTLE_CYC - 1);

  typedef enum logic [2:0] {DIS, EN_WAIT, IDLE, DIR_SETUP, PULSE_HI, PULSE_LO} state_t;

  state_t             state, state_n;
  logic [15:0]        cnt, cnt_n;
  logic               slot_v, slot_v_n, slot_d, slot_d_n;
  logic               dir_n, step_used, req_dir;
  logic [POS_W-1:0]   pos_n;
  logic [15:0]        drop_n;

  assign req_dir = slot_v ? slot_d : i_dir;

`ifdef MOTOR_SOFT_LIMIT_EN
  logic signed [POS_W:0] tgt;
  logic                  lim_hit, limit_n;

  always_comb begin
    tgt     = req_dir ? {o_pos[POS_W-1], o_pos} + (POS_W+1)'(1)
                      : {o_pos[POS_W-1], o_pos} - (POS_W+1)'(1);
    lim_hit = (tgt < $signed({i_pos_min[POS_W-1], i_pos_min})) ||
              (tgt > $signed({i_pos_max[POS_W-1], i_pos_max}));
  end
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    slot_v_n  = slot_v;
    slot_d_n  = slot_d;
    dir_n     = o_motor_dir;
    pos_n     = o_pos;
    drop_n    = o_drop_cnt;
    step_used = 1'b0;
`ifdef MOTOR_SOFT_LIMIT_EN
    limit_n   = o_limit;
`endif
    if (state != DIS && !i_en) begin
      // Abort: pending request is discarded; a strobe arriving now refills the emptied slot.
      state_n  = DIS;
      slot_v_n = i_step;
      slot_d_n = i_dir;
    end else begin
      unique case (state)
        DIS: if (i_en) begin
          state_n = EN_WAIT;
          cnt_n   = EN_LD;
        end
        EN_WAIT: if (cnt == '0) state_n = IDLE;
                 else           cnt_n   = cnt - 16'd1;
        IDLE: if (slot_v || i_step) begin
          step_used = !slot_v;
          slot_v_n  = 1'b0;
`ifdef MOTOR_SOFT_LIMIT_EN
          if (lim_hit) limit_n = 1'b1;
          else begin
            limit_n = 1'b0;
`else
          begin
`endif
            if (req_dir == o_motor_dir) begin
              state_n = PULSE_HI;
              cnt_n   = HI_LD;
            end else begin
              dir_n   = req_dir;
              state_n = DIR_SETUP;
              cnt_n   = SETUP_LD;
            end
          end
        end
        DIR_SETUP: if (cnt == '0) begin
          state_n = PULSE_HI;
          cnt_n   = HI_LD;
        end else cnt_n = cnt - 16'd1;
        PULSE_HI: if (cnt == '0) begin
          state_n = PULSE_LO;
          cnt_n   = LO_LD;
        end else cnt_n = cnt - 16'd1;
        PULSE_LO: if (cnt == '0) state_n = IDLE;
                  else           cnt_n   = cnt - 16'd1;
        default: state_n = DIS;
      endcase
      if (i_step && !step_used) begin
        if (!slot_v_n) begin
          slot_v_n = 1'b1;
          slot_d_n = i_dir;
        end else if (o_drop_cnt != '1) begin
          drop_n = o_drop_cnt + 16'd1;
        end
      end
      if (state_n == PULSE_HI && state != PULSE_HI)
        pos_n = dir_n ? o_pos + POS_W'(1) : o_pos - POS_W'(1);
    end
    if (i_pos_clr) begin
      pos_n  = '0;
      drop_n = '0;
`ifdef MOTOR_SOFT_LIMIT_EN
      limit_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= DIS;
      cnt              <= '0;
      slot_v           <= 1'b0;
      slot_d           <= 1'b0;
      o_motor_step     <= 1'b0;
      o_motor_dir      <= 1'b0;
      o_motor_en       <= 1'b0;
      o_motor_hold_off <= 1'b0;
      o_busy           <= 1'b0;
      o_pos            <= '0;
      o_drop_cnt       <= '0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      slot_v           <= slot_v_n;
      slot_d           <= slot_d_n;
      o_motor_step     <= (state_n == PULSE_HI);
      o_motor_dir      <= dir_n;
      o_motor_en       <= (state_n != DIS);
      o_motor_hold_off <= i_hold_off;
      o_busy           <= (state_n != IDLE) || slot_v_n;
      o_pos            <= pos_n;
      o_drop_cnt       <= drop_n;
    end
  end

`ifdef MOTOR_SOFT_LIMIT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_limit <= 1'b0;
    else       o_limit <= limit_n;
  end
`endif

endmodule

// File: tb/tb_motor_step_drv_if.sv
// Bench for motor_step_drv_if: directed scenarios plus random traffic against a timestamp-based reference model.
module tb_motor_step_drv_if;

  localparam int E = 5000, S = 500, H = 100, L = 100;
  localparam longint FAR = -1000000;

  logic        clk = 1'b0;
  logic        i_rst, i_step, i_dir, i_en, i_hold_off, i_pos_clr;
  logic        o_motor_step, o_motor_dir, o_motor_en, o_motor_hold_off, o_busy;
  logic [31:0] o_pos;
  logic [15:0] o_drop_cnt;
`ifdef MOTOR_SOFT_LIMIT_EN
  logic signed [31:0] pos_min, pos_max;
  logic               o_limit;
`endif

  always #5 clk = ~clk;

  motor_step_drv_if dut (
    .i_clk(clk), .i_rst(i_rst), .i_step(i_step), .i_dir(i_dir), .i_en(i_en),
    .i_hold_off(i_hold_off), .i_pos_clr(i_pos_clr),
`ifdef MOTOR_SOFT_LIMIT_EN
    .i_pos_min(pos_min), .i_pos_max(pos_max), .o_limit(o_limit),
`endif
    .o_motor_step(o_motor_step), .o_motor_dir(o_motor_dir), .o_motor_en(o_motor_en),
    .o_motor_hold_off(o_motor_hold_off), .o_busy(o_busy), .o_pos(o_pos), .o_drop_cnt(o_drop_cnt)
  );

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: pin behaviour expressed as edge timestamps (enable, idle, pulse rise).
  longint n = 0, idle_edge = 0, rise = FAR;
  bit en_m, dir_m, slot_v, slot_d, step_m, busy_m, hold_m, lim_m;
  logic [31:0] pos_m;
  int drop_m;

  task automatic model_edge();
    bit was_en, taken, req, hit;
    n++;
    if (i_rst) begin
      en_m = 0; dir_m = 0; slot_v = 0; slot_d = 0; pos_m = '0; drop_m = 0;
      rise = FAR; idle_edge = 0; step_m = 0; busy_m = 0; hold_m = 0; lim_m = 0;
      return;
    end
    hold_m = i_hold_off;
    if (en_m && !i_en) begin
      en_m = 0; rise = FAR; slot_v = i_step; slot_d = i_dir;
    end else begin
      was_en = en_m;
      taken  = 0;
      if (!en_m && i_en) begin en_m = 1; idle_edge = n + E + 1; end
      if (was_en && n >= idle_edge && (slot_v || i_step)) begin
        req   = slot_v ? slot_d : i_dir;
        taken = !slot_v;
        slot_v = 0;
        hit = 0;
`ifdef MOTOR_SOFT_LIMIT_EN
        begin
          longint t = longint'($signed(pos_m)) + (req ? 1 : -1);
          hit = (t < longint'(pos_min)) || (t > longint'(pos_max));
        end
`endif
        if (hit) lim_m = 1;
        else begin
          lim_m = 0;
          if (req == dir_m) rise = n;
          else begin dir_m = req; rise = n + S; end
          idle_edge = rise + H + L + 1;
        end
      end
      if (i_step && !taken) begin
        if (!slot_v) begin slot_v = 1; slot_d = i_dir; end
        else if (drop_m < 65535) drop_m++;
      end
      if (n == rise) pos_m = dir_m ? pos_m + 1 : pos_m - 1;
    end
    if (i_pos_clr) begin pos_m = '0; drop_m = 0; lim_m = 0; end
    step_m = en_m && n >= rise && n < rise + H;
    busy_m = !(en_m && n + 1 >= idle_edge) || slot_v;
  endtask

  // DUT-side event tracking for the directed timing checks.
  longint t_en_rise = 0, t_step_rise = 0, t_dir_chg = 0;
  int rises = 0, hi_cnt = 0, busy_cnt = 0;
  logic prev_step = 0, prev_en = 0, prev_dir = 0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("step", o_motor_step, step_m);
    check("dir", o_motor_dir, dir_m);
    check("en", o_motor_en, en_m);
    check("hold_off", o_motor_hold_off, hold_m);
    check("busy", o_busy, busy_m);
    check("pos", o_pos, pos_m);
    check("drop", o_drop_cnt, drop_m);
`ifdef MOTOR_SOFT_LIMIT_EN
    check("limit", o_limit, lim_m);
`endif
    if (o_motor_step === 1'b1 && prev_step !== 1'b1) begin rises++; t_step_rise = n; end
    if (o_motor_en === 1'b1 && prev_en !== 1'b1) t_en_rise = n;
    if (o_motor_dir !== prev_dir) t_dir_chg = n;
    if (o_motor_step === 1'b1) hi_cnt++;
    if (o_busy === 1'b1) busy_cnt++;
    prev_step = o_motor_step; prev_en = o_motor_en; prev_dir = o_motor_dir;
  endtask

  task automatic wait_rise(input int budget);
    int r0 = rises, k = 0;
    while (rises == r0 && k < budget) begin tick(); k++; end
    check("wait_rise_timeout", rises == r0, 0);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (o_busy !== 1'b0 && k < budget) begin tick(); k++; end
    check("wait_idle_timeout", o_busy !== 1'b0, 0);
  endtask

  task automatic strobe(input logic d);
    i_step = 1; i_dir = d; tick(); i_step = 0;
  endtask

  initial begin
    int r0;
    i_rst = 1; i_step = 0; i_dir = 0; i_en = 0; i_hold_off = 0; i_pos_clr = 0;
`ifdef MOTOR_SOFT_LIMIT_EN
    pos_min = -1000000; pos_max = 1000000;
`endif
    repeat (3) tick();
    check("rst_busy", o_busy, 0);
    check("rst_pos", o_pos, 0);
    check("rst_en", o_motor_en, 0);
    i_rst = 0; i_en = 1;

    // Buffered strobe during settle; dir matches the pin so no setup delay.
    repeat (10) tick();
    strobe(0);
    wait_rise(6000);
    check("settle_latency", t_step_rise - t_en_rise, E + 1);
    wait_idle(1000);
    check("pos_minus1", o_pos, 32'hFFFF_FFFF);

    strobe(1);
    wait_rise(1000);
    check("dir_setup", t_step_rise - t_dir_chg, S);
    wait_idle(1000);
    check("pos_back0", o_pos, 0);

    hi_cnt = 0; busy_cnt = 0;
    strobe(1);
    wait_idle(1000);
    check("pulse_hi_width", hi_cnt, H);
    check("busy_span", busy_cnt, H + L);
    check("pos_plus1", o_pos, 1);

    r0 = rises;
    i_step = 1; i_dir = 1; repeat (3) tick(); i_step = 0;
    wait_idle(2000);
    check("burst_pulses", rises - r0, 2);
    check("burst_drop", o_drop_cnt, 1);
    check("burst_pos", o_pos, 3);

    // Abort in the 40th high cycle with a request pending.
    strobe(1);
    strobe(1);
    repeat (37) tick();
    i_en = 0; tick();
    check("abort_step", o_motor_step, 0);
    check("abort_en", o_motor_en, 0);
    check("abort_pos", o_pos, 4);
    i_en = 1;
    r0 = rises;
    wait_idle(6000);
    check("abort_pending_cleared", rises - r0, 0);

`ifdef MOTOR_SOFT_LIMIT_EN
    i_pos_clr = 1; tick(); i_pos_clr = 0;
    pos_min = -10; pos_max = 2;
    repeat (3) begin strobe(1); wait_idle(1000); end
    check("lim_pos", o_pos, 2);
    check("lim_flag", o_limit, 1);
    i_pos_clr = 1; tick(); i_pos_clr = 0;
    check("lim_clr_pos", o_pos, 0);
    check("lim_clr_flag", o_limit, 0);
    pos_min = -3; pos_max = 3;
`endif

    for (int c = 0; c < 25000; c++) begin
      i_step     = ($urandom_range(0, 119) == 0);
      if (i_step) i_dir = $urandom_range(0, 1);
      i_hold_off = $urandom_range(0, 1);
      i_pos_clr  = ($urandom_range(0, 3999) == 0);
      if (i_en) i_en = ($urandom_range(0, 5999) != 0);
      else      i_en = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
